// File: rtl/dmem_port_arbiter_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int PORT_MEM = 0;
    localparam int PORT_DBG = 1;

    // Wait counter is never narrower than one bit, even for WAIT_CYCLES == 0.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage : dmem_arb_pkg

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Requester and memory-side signal bundle for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0,   req1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              done0,  done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_addr, mem_we, mem_wdata, busy
    );
endinterface : dmem_port_arbiter_if

`default_nettype wire

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way picker; round-robin by default,
//               fixed priority (port 0 wins) when DMEM_ARB_FIXED_PRI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  wire logic [1:0] i_req,
    input  wire logic       i_ptr,
    output logic      [1:0] o_gnt,
    output logic            o_ptr_nxt
);

`ifdef DMEM_ARB_FIXED_PRI_EN
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[PORT_MEM])
            o_gnt[PORT_MEM] = 1'b1;
        else if (i_req[PORT_DBG])
            o_gnt[PORT_DBG] = 1'b1;
    end
`else
    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11)
            o_gnt[i_ptr] = 1'b1;
        else
            o_gnt = i_req;
    end
`endif

    // After a grant the pointer favours the port that just lost out.
    always_comb begin
        o_ptr_nxt = i_ptr;
        if (|o_gnt)
            o_ptr_nxt = o_gnt[PORT_MEM];
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-port arbiter/sequencer in front of a single-port data
//               memory. Option macro: DMEM_ARB_FIXED_PRI_EN (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    dmem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done0, r_done1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic [1:0]        w_req, w_pick, w_grant;
    logic              w_ptr, w_ptr_nxt, w_last;

    assign w_req  = {bus.req1, bus.req0};
    assign w_last = (r_state == ST_BUSY) && (r_cnt == '0);

`ifdef DMEM_ARB_FIXED_PRI_EN
    logic w_unused_ptr_nxt;
    assign w_ptr            = 1'b0;
    assign w_unused_ptr_nxt = w_ptr_nxt;
`else
    logic r_ptr;
    assign w_ptr = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 1'b0;
        else if (|w_grant)
            r_ptr <= w_ptr_nxt;
    end
`endif

    rr_arb2 u_pick (
        .i_req     (w_req),
        .i_ptr     (w_ptr),
        .o_gnt     (w_pick),
        .o_ptr_nxt (w_ptr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant     = w_pick;
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_IDLE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (|w_grant) begin
                r_port  <= w_grant[PORT_DBG];
                r_we    <= w_grant[PORT_DBG] ? bus.we1    : bus.we0;
                r_addr  <= w_grant[PORT_DBG] ? bus.addr1  : bus.addr0;
                r_wdata <= w_grant[PORT_DBG] ? bus.wdata1 : bus.wdata0;
            end
            // Completion: writes leave the port's read data untouched.
            if (w_last) begin
                if (r_port) begin
                    r_done1 <= 1'b1;
                    if (!r_we)
                        r_rdata1 <= bus.mem_rdata;
                end else begin
                    r_done0 <= 1'b1;
                    if (!r_we)
                        r_rdata0 <= bus.mem_rdata;
                end
            end
        end
    end

    // Grants are suppressed while reset is held so every output reads 0.
    assign bus.gnt0      = w_grant[PORT_MEM] & rst_n;
    assign bus.gnt1      = w_grant[PORT_DBG] & rst_n;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.mem_addr  = (r_state == ST_BUSY) ? r_addr  : '0;
    assign bus.mem_wdata = (r_state == ST_BUSY) ? r_wdata : '0;
    assign bus.mem_we    = w_last & r_we;

endmodule : dmem_port_arbiter

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter with memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int W  = 1;
`ifdef DMEM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_load = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[1] <= 8'd2;
            mem[6] <= 8'd66;
            mem[8] <= 8'd1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int checks = 0;
    int errors = 0;
    int exp_ptr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd6; bus.wdata0 = '0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd8; bus.wdata1 = 8'hFF;
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {bus.gnt1, bus.gnt0}); end
        checks++; if ({bus.done1, bus.done0} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", {bus.done1, bus.done0}); end
        checks++; if ({bus.rdata1, bus.rdata0} !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", {bus.rdata1, bus.rdata0}); end
        checks++; if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== 17'h0) begin errors++; $display("FAIL reset_mem got=%h/%b/%h exp=0", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        mem_load = 1'b0;
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_single_read();
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd6;
        @(negedge clk);
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", {bus.gnt1, bus.gnt0}); end
        exp_ptr = 1;
        tick();
        bus.req0 = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.done0 !== 1'b0 || bus.mem_addr !== 8'd6 || bus.mem_we !== 1'b0) begin
                errors++; $display("FAIL single_busy k=%0d busy=%b done0=%b addr=%0d we=%b exp=1/0/6/0", k, bus.busy, bus.done0, bus.mem_addr, bus.mem_we);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.done0 !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_done done0=%b busy=%b exp=1/0", bus.done0, bus.busy); end
        checks++; if (bus.rdata0 !== 8'd66) begin errors++; $display("FAIL single_rdata got=%0d exp=66", bus.rdata0); end
        tick();
    endtask

    task automatic test_alternate();
        int t = 0, last_t = -1, last_w = -1, ngr = 0, exp_w;
        logic [1:0] g;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd8;
        while (ngr < 6 && t < 60) begin
            @(negedge clk);
            g = {bus.gnt1, bus.gnt0};
            if (last_w >= 0 && t == last_t + W + 2) begin
                checks++;
                if ({bus.done1, bus.done0} !== onehot(last_w) || (last_w == 1 ? bus.rdata1 : bus.rdata0) !== (last_w == 1 ? 8'd1 : 8'd2)) begin
                    errors++; $display("FAIL alt_done t=%0d done=%b rd0=%0d rd1=%0d port=%0d", t, {bus.done1, bus.done0}, bus.rdata0, bus.rdata1, last_w);
                end
            end
            if (g != 2'b00) begin
                exp_w = FIXED ? 0 : exp_ptr;
                checks++; if (g !== onehot(exp_w)) begin errors++; $display("FAIL alt_gnt t=%0d got=%b exp=%b", t, g, onehot(exp_w)); end
                if (last_t >= 0) begin
                    checks++; if (t != last_t + W + 2) begin errors++; $display("FAIL alt_spacing got=%0d exp=%0d", t - last_t, W + 2); end
                end
                last_t = t; last_w = exp_w; exp_ptr = 1 - exp_w; ngr++;
            end
            tick(); t++;
        end
        checks++; if (ngr < 6) begin errors++; $display("FAIL alt_timeout grants=%0d exp=6", ngr); end
        // Port 0 withdraws; port 1 must be granted in the next done cycle.
        bus.req0 = 1'b0;
        while (t < last_t + W + 2) begin tick(); t++; end
        @(negedge clk);
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10 || {bus.done1, bus.done0} !== onehot(last_w)) begin
            errors++; $display("FAIL alt_solo gnt=%b done=%b exp=10/%b", {bus.gnt1, bus.gnt0}, {bus.done1, bus.done0}, onehot(last_w));
        end
        exp_ptr = 0; last_t = t;
        tick(); t++;
        bus.req1 = 1'b0;
        while (t < last_t + W + 2) begin tick(); t++; end
        @(negedge clk);
        checks++; if (bus.done1 !== 1'b1 || bus.rdata1 !== 8'd1) begin errors++; $display("FAIL alt_solo_done done1=%b rd1=%0d exp=1/1", bus.done1, bus.rdata1); end
        tick();
    endtask

    task automatic test_write_read();
        int we_cnt = 0;
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd6; bus.wdata1 = 8'h5A;
        @(negedge clk);
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", {bus.gnt1, bus.gnt0}); end
        exp_ptr = 0;
        tick();
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd6;
        for (int t = 1; t <= 2 * (W + 2); t++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_cnt++;
                checks++; if (bus.mem_addr !== 8'd6 || bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL wr_bus addr=%0d data=%h exp=6/5a", bus.mem_addr, bus.mem_wdata); end
            end
            if (t == W + 2) begin
                checks++; if (bus.done1 !== 1'b1 || {bus.gnt1, bus.gnt0} !== 2'b01 || bus.rdata1 !== 8'd1) begin
                    errors++; $display("FAIL wr_done done1=%b gnt=%b rd1=%0d exp=1/01/1", bus.done1, {bus.gnt1, bus.gnt0}, bus.rdata1);
                end
                exp_ptr = 1;
            end
            if (t == 2 * (W + 2)) begin
                checks++; if (bus.done0 !== 1'b1 || bus.rdata0 !== 8'h5A) begin errors++; $display("FAIL rd_back done0=%b rd0=%h exp=1/5a", bus.done0, bus.rdata0); end
            end
            tick();
            if (t == W + 2) bus.req0 = 1'b0;
        end
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL wr_we_count got=%0d exp=1", we_cnt); end
    endtask

    task automatic test_busy_ignore();
        int d0 = 0, d1 = 0;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd1;
        @(negedge clk);
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL busy_gnt0 got=%b exp=01", {bus.gnt1, bus.gnt0}); end
        exp_ptr = 1;
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd8;
        for (int t = 1; t <= 2 * (W + 2); t++) begin
            @(negedge clk);
            d0 += int'(bus.done0); d1 += int'(bus.done1);
            if (t <= W + 1) begin
                checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL busy_hold t=%0d gnt1=%b exp=0", t, bus.gnt1); end
            end
            if (t == W + 2) begin
                checks++; if (bus.gnt1 !== 1'b1 || bus.done0 !== 1'b1 || bus.rdata0 !== 8'd2) begin
                    errors++; $display("FAIL busy_handover gnt1=%b done0=%b rd0=%0d exp=1/1/2", bus.gnt1, bus.done0, bus.rdata0);
                end
                exp_ptr = 0;
            end
            tick();
            if (t == W + 2) bus.req1 = 1'b0;
        end
        checks++; if (d0 != 1 || d1 != 1 || bus.rdata1 !== 8'd1) begin errors++; $display("FAIL busy_count done0=%0d done1=%0d rd1=%0d exp=1/1/1", d0, d1, bus.rdata1); end
    endtask

    task automatic test_reset_mid_write();
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd8; bus.wdata0 = 8'h77;
        @(negedge clk);
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL rstw_gnt got=%b exp=1", bus.gnt0); end
        tick();
        bus.req0 = 1'b0;
        for (int k = 1; k <= W; k++) tick();
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rstw_we_pre got=%b exp=1", bus.mem_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 8'd0) begin
            errors++; $display("FAIL rstw_drop we=%b busy=%b addr=%0d wd=%h exp=0", bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        @(negedge clk);
        checks++; if ({bus.done1, bus.done0, bus.gnt1, bus.gnt0} !== 4'b0 || {bus.rdata1, bus.rdata0} !== 16'h0) begin
            errors++; $display("FAIL rstw_outputs done=%b gnt=%b rd=%h exp=0", {bus.done1, bus.done0}, {bus.gnt1, bus.gnt0}, {bus.rdata1, bus.rdata0});
        end
        checks++; if (mem[8] !== 8'd1) begin errors++; $display("FAIL rstw_mem8 got=%0d exp=1", mem[8]); end
        tick();
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [0:15];
        logic [7:0] rd_exp [0:1];
        bit   pend [0:1];
        bit   p_we [0:1];
        logic [7:0] p_addr [0:1];
        logic [7:0] p_wd [0:1];
        int   g_at = -100, done_at = -100, cur_port = 0, w;
        bit   cur_we = 1'b0;
        logic [7:0] cur_addr = '0, cur_wd = '0;
        logic [1:0] exp_g, exp_d;
        bit   exp_busy, exp_we;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        ref_mem[1] = 8'd2; ref_mem[6] = 8'h5A; ref_mem[8] = 8'd1;
        rd_exp[0] = 8'd0; rd_exp[1] = 8'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && $urandom_range(0, 9) == 0) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1; p_we[p] = $urandom_range(0, 1) == 1;
                    p_addr[p] = 8'($urandom_range(0, 15)); p_wd[p] = 8'($urandom);
                end
            end
            bus.req0 = pend[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wd[0];
            bus.req1 = pend[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wd[1];
            @(negedge clk);
            if (t == done_at) begin
                if (cur_we) ref_mem[cur_addr[3:0]] = cur_wd;
                else        rd_exp[cur_port] = ref_mem[cur_addr[3:0]];
            end
            exp_g = 2'b00; w = 0;
            if (t >= done_at && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? (FIXED ? 0 : exp_ptr) : (pend[1] ? 1 : 0);
                exp_g = onehot(w);
            end
            exp_d    = (t == done_at) ? onehot(cur_port) : 2'b00;
            exp_busy = (t > g_at) && (t < done_at);
            exp_we   = (t == done_at - 1) && cur_we;
            checks++; if ({bus.gnt1, bus.gnt0} !== exp_g) begin errors++; $display("FAIL rnd_gnt t=%0d got=%b exp=%b", t, {bus.gnt1, bus.gnt0}, exp_g); end
            checks++; if ({bus.done1, bus.done0} !== exp_d) begin errors++; $display("FAIL rnd_done t=%0d got=%b exp=%b", t, {bus.done1, bus.done0}, exp_d); end
            checks++; if (bus.busy !== exp_busy || bus.mem_we !== exp_we) begin errors++; $display("FAIL rnd_busy_we t=%0d got=%b/%b exp=%b/%b", t, bus.busy, bus.mem_we, exp_busy, exp_we); end
            checks++; if (bus.rdata0 !== rd_exp[0] || bus.rdata1 !== rd_exp[1]) begin errors++; $display("FAIL rnd_rdata t=%0d got=%h/%h exp=%h/%h", t, bus.rdata0, bus.rdata1, rd_exp[0], rd_exp[1]); end
            checks++;
            if (bus.mem_addr !== (exp_busy ? cur_addr : 8'd0) || bus.mem_wdata !== (exp_busy ? cur_wd : 8'd0)) begin
                errors++; $display("FAIL rnd_membus t=%0d got=%h/%h exp=%h/%h", t, bus.mem_addr, bus.mem_wdata, exp_busy ? cur_addr : 8'd0, exp_busy ? cur_wd : 8'd0);
            end
            if (exp_g != 2'b00) begin
                g_at = t; done_at = t + W + 2; cur_port = w;
                cur_we = p_we[w]; cur_addr = p_addr[w]; cur_wd = p_wd[w];
                exp_ptr = 1 - w; pend[w] = 1'b0;
            end
        end
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int k = 0; k < W + 3; k++) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_write_read();
        test_busy_ignore();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dmem_port_arbiter

`default_nettype wire
